// File: rtl/vga_pkg.sv
// vga_pkg: shared state encoding, ASCII codes, default geometry and a
// modular row-add helper for the VGA text writer.
package vga_pkg;

   localparam int DEFAULT_COLS = 70;
   localparam int DEFAULT_ROWS = 30;

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_TILDE = 8'h7E;

   // (a + b) mod n, valid when both operands are already below n.
   function automatic logic [4:0] row_add(input logic [4:0] a,
                                          input logic [4:0] b,
                                          input logic [5:0] n);
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= n) s = s - n;
      return s[4:0];
   endfunction

endpackage

// File: rtl/vga_cell_sweep.sv
// vga_cell_sweep: column/row counter producing sweep addresses for the
// full-screen blank (row stepping on) and the single-row clear (row
// stepping off). Both modes leave the counter back at (0,0) when done.
module vga_cell_sweep
   import vga_pkg::*;
#(
   parameter int COLS = DEFAULT_COLS,
   parameter int ROWS = DEFAULT_ROWS
) (
   input  logic       pclk,
   input  logic       reset,
   input  logic       i_en,
   input  logic       i_row_step,
   output logic [6:0] o_col,
   output logic [4:0] o_row,
   output logic       o_last_col,
   output logic       o_last_row
);

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   logic [6:0] r_col;
   logic [4:0] r_row;

   // Advance one cell per enabled cycle, wrapping column then row.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_en) begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so order of statements cannot create races.
         if (o_last_col) begin
            r_col <= '0;
            if (i_row_step) r_row <= o_last_row ? '0 : r_row + 5'd1;
         end else begin
            r_col <= r_col + 7'd1;
         end
      end
   end

   assign o_col      = r_col;
   assign o_row      = r_row;
   assign o_last_col = (r_col == LAST_COL);
   assign o_last_row = (r_row == LAST_ROW);

endmodule

// File: rtl/vga_text_writer.sv
// vga_text_writer: turns a byte stream into text-memory writes, tracks the
// cursor, handles BS/LF/CR and scrolls by rotating row_base and blanking the
// newly exposed bottom row.
// Build option: VGA_WRITER_INIT_CLEAR_EN -- blank all cells after reset
// before accepting characters.
module vga_text_writer
   import vga_pkg::*;
#(
   parameter int COLS = DEFAULT_COLS,
   parameter int ROWS = DEFAULT_ROWS
) (
   input  logic       pclk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_char,
   output logic       in_ready,
   output logic       vram_we,
   output logic [6:0] vram_x,
   output logic [4:0] vram_y,
   output logic [7:0] vram_wdata,
   output logic [4:0] row_base,
   output logic [6:0] cursor_x,
   output logic [4:0] cursor_y
);

`ifdef VGA_WRITER_INIT_CLEAR_EN
   localparam logic [1:0] RESET_STATE = ST_INIT;
`else
   localparam logic [1:0] RESET_STATE = ST_IDLE;
`endif

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [5:0] NUM_ROWS = 6'(ROWS);

   logic [1:0] r_state;
   logic [6:0] r_cx;
   logic [4:0] r_cy;
   logic [4:0] r_base;
   logic       r_we;
   logic [6:0] r_x;
   logic [4:0] r_y;
   logic [7:0] r_wd;

   logic       w_accept;
   logic       w_printable;
   logic       w_wrap;
   logic       w_advance;
   logic       w_bottom;
   logic [4:0] w_phys_row;
   logic [4:0] w_clear_row;
   logic       w_sw_en;
   logic [6:0] w_sw_col;
   logic [4:0] w_sw_row;
   logic       w_sw_last_col;
   logic       w_sw_last_row;

   // Ready is a pure decode of IDLE, forced low while reset is held.
   assign in_ready    = (r_state == ST_IDLE) && !reset;
   assign w_accept    = in_valid && in_ready;
   assign w_printable = (in_char >= ASCII_SPACE) && (in_char <= ASCII_TILDE);
   assign w_wrap      = w_printable && (r_cx == LAST_COL);
   assign w_advance   = w_accept && (w_wrap || (in_char == ASCII_LF));
   assign w_bottom    = (r_cy == LAST_ROW);
   assign w_phys_row  = row_add(r_cy, r_base, NUM_ROWS);
   // Uses the already-incremented row_base, i.e. the row just scrolled in.
   assign w_clear_row = row_add(LAST_ROW, r_base, NUM_ROWS);
   assign w_sw_en     = (r_state == ST_INIT) || (r_state == ST_CLEAR);

   vga_cell_sweep #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_sweep (
      .pclk       (pclk),
      .reset      (reset),
      .i_en       (w_sw_en),
      .i_row_step (r_state == ST_INIT),
      .o_col      (w_sw_col),
      .o_row      (w_sw_row),
      .o_last_col (w_sw_last_col),
      .o_last_row (w_sw_last_row)
   );

   // FSM, cursor, scroll base and registered write port.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_state <= RESET_STATE;
         r_cx    <= '0;
         r_cy    <= '0;
         r_base  <= '0;
         r_we    <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_wd    <= '0;
      end else begin
         // NOTE: default the strobe low every cycle so it is a single-cycle pulse unless a branch re-asserts it.
         r_we <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_we <= 1'b1;
               r_x  <= w_sw_col;
               r_y  <= w_sw_row;
               r_wd <= ASCII_SPACE;
               if (w_sw_last_col && w_sw_last_row) r_state <= ST_IDLE;
            end
            ST_CLEAR: begin
               r_we <= 1'b1;
               r_x  <= w_sw_col;
               r_y  <= w_clear_row;
               r_wd <= ASCII_SPACE;
               if (w_sw_last_col) r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_printable) begin
                     r_we <= 1'b1;
                     r_x  <= r_cx;
                     r_y  <= w_phys_row;
                     r_wd <= in_char;
                     r_cx <= w_wrap ? '0 : r_cx + 7'd1;
                  end else if ((in_char == ASCII_LF) || (in_char == ASCII_CR)) begin
                     r_cx <= '0;
                  end else if ((in_char == ASCII_BS) && (r_cx != '0)) begin
                     r_cx <= r_cx - 7'd1;
                     r_we <= 1'b1;
                     r_x  <= r_cx - 7'd1;
                     r_y  <= w_phys_row;
                     r_wd <= ASCII_SPACE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Row advance: scroll at the bottom, otherwise move down one row.
         if (w_advance) begin
            if (w_bottom) begin
               r_base  <= row_add(r_base, 5'd1, NUM_ROWS);
               r_state <= ST_CLEAR;
            end else begin
               r_cy <= r_cy + 5'd1;
            end
         end
      end
   end

   assign vram_we    = r_we;
   assign vram_x     = r_x;
   assign vram_y     = r_y;
   assign vram_wdata = r_wd;
   assign row_base   = r_base;
   assign cursor_x   = r_cx;
   assign cursor_y   = r_cy;

endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: drives characters into vga_text_writer and compares
// every vram write, in_ready each cycle, and the cursor/row_base against a
// behavioural model of the terminal (cursor, scroll base, pending blank time).
// Build option: VGA_WRITER_INIT_CLEAR_EN -- model includes the post-reset blank.
module tb_vga_text_writer;

   localparam int COLS = 70;
   localparam int ROWS = 30;

   typedef struct packed {
      logic [6:0] x;
      logic [4:0] y;
      logic [7:0] d;
   } wr_t;

   logic       pclk     = 1'b0;
   logic       reset    = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_char  = 8'h00;
   logic       in_ready;
   logic       vram_we;
   logic [6:0] vram_x;
   logic [4:0] vram_y;
   logic [7:0] vram_wdata;
   logic [4:0] row_base;
   logic [6:0] cursor_x;
   logic [4:0] cursor_y;

   vga_text_writer #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) dut (
      .pclk       (pclk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_char    (in_char),
      .in_ready   (in_ready),
      .vram_we    (vram_we),
      .vram_x     (vram_x),
      .vram_y     (vram_y),
      .vram_wdata (vram_wdata),
      .row_base   (row_base),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y)
   );

   always #20 pclk = ~pclk;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   // Terminal model state.
   int m_cx, m_cy, m_base, m_busy;

   // Capture writes just after the edge that issues them.
   always @(posedge pclk) begin
      #1;
      if (vram_we === 1'b1) obs_q.push_back({vram_x, vram_y, vram_wdata});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   task automatic push_write(input int x, input int y, input int d);
      wr_t w;
      w.x = 7'(x);
      w.y = 5'(y);
      w.d = 8'(d);
      exp_q.push_back(w);
   endtask

   task automatic model_newline();
      if (m_cy == ROWS - 1) begin
         m_base = (m_base + 1) % ROWS;
         m_busy = COLS;
         for (int x = 0; x < COLS; x++) push_write(x, (m_base + ROWS - 1) % ROWS, 8'h20);
      end else begin
         m_cy++;
      end
   endtask

   task automatic model_accept(input int c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         push_write(m_cx, (m_cy + m_base) % ROWS, c);
         if (m_cx == COLS - 1) begin
            m_cx = 0;
            model_newline();
         end else begin
            m_cx++;
         end
      end else if (c == 8'h0A) begin
         m_cx = 0;
         model_newline();
      end else if (c == 8'h0D) begin
         m_cx = 0;
      end else if (c == 8'h08) begin
         if (m_cx > 0) begin
            m_cx--;
            push_write(m_cx, (m_cy + m_base) % ROWS, 8'h20);
         end
      end
   endtask

   // ---------------- stimulus primitives ----------------
   // One clock: drive at negedge, check ready against the model, step model.
   task automatic cycle(input bit v, input logic [7:0] c);
      bit exp_ready;
      in_valid = v;
      in_char  = c;
      #1;
      exp_ready = (m_busy == 0);
      n_checks++;
      if (in_ready !== exp_ready)
         $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_ready);
      else
         n_pass++;
      if (v && exp_ready) model_accept(int'(c));
      else if (m_busy > 0) m_busy--;
      @(negedge pclk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4000 && m_busy > 0; i++) cycle(1'b0, 8'h00);
   endtask

   task automatic do_reset(input string tag);
      in_valid = 1'b0;
      in_char  = 8'h00;
      reset    = 1'b1;
      @(negedge pclk);
      @(negedge pclk);
      n_checks++;
      if ({vram_we, vram_x, vram_y, vram_wdata} !== 21'd0)
         $display("FAIL %s_vram_reset: got we=%b x=%0d y=%0d d=%h expected all zero",
                  tag, vram_we, vram_x, vram_y, vram_wdata);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0)
         $display("FAIL %s_ready_reset: got %b expected 0", tag, in_ready);
      else n_pass++;
      n_checks++;
      if ({cursor_x, cursor_y, row_base} !== 17'd0)
         $display("FAIL %s_cursor_reset: got x=%0d y=%0d base=%0d expected 0,0,0",
                  tag, cursor_x, cursor_y, row_base);
      else n_pass++;
      reset  = 1'b0;
      m_cx   = 0;
      m_cy   = 0;
      m_base = 0;
      m_busy = 0;
      exp_q.delete();
      obs_q.delete();
`ifdef VGA_WRITER_INIT_CLEAR_EN
      m_busy = ROWS * COLS;
      for (int r = 0; r < ROWS; r++)
         for (int x = 0; x < COLS; x++) push_write(x, r, 8'h20);
`endif
   endtask

   task automatic check_cursor(input string tag);
      n_checks++;
      if (cursor_x !== 7'(m_cx)) $display("FAIL %s_cursor_x: got %0d expected %0d", tag, cursor_x, m_cx);
      else n_pass++;
      n_checks++;
      if (cursor_y !== 5'(m_cy)) $display("FAIL %s_cursor_y: got %0d expected %0d", tag, cursor_y, m_cy);
      else n_pass++;
      n_checks++;
      if (row_base !== 5'(m_base)) $display("FAIL %s_row_base: got %0d expected %0d", tag, row_base, m_base);
      else n_pass++;
   endtask

   task automatic check_writes(input string tag);
      n_checks++;
      if (obs_q.size() !== exp_q.size())
         $display("FAIL %s_write_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i])
            $display("FAIL %s_write[%0d]: got x=%0d y=%0d d=%h expected x=%0d y=%0d d=%h", tag, i,
                     obs_q[i].x, obs_q[i].y, obs_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d);
         else n_pass++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   function automatic logic [7:0] rand_printable();
      return 8'($urandom_range(32, 126));
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset("reset");
      wait_idle();
      check_cursor("reset");
      check_writes("reset");
   endtask

   task automatic test_single_char();
      do_reset("single");
      wait_idle();
      check_writes("single_init");
      cycle(1'b1, 8'h41);
      n_checks++;
      if ({vram_we, vram_x, vram_y, vram_wdata} !== {1'b1, 7'd0, 5'd0, 8'h41})
         $display("FAIL single_write: got we=%b x=%0d y=%0d d=%h expected we=1 x=0 y=0 d=41",
                  vram_we, vram_x, vram_y, vram_wdata);
      else n_pass++;
      check_cursor("single");
      check_writes("single");
   endtask

   task automatic test_back_to_back();
      do_reset("b2b");
      wait_idle();
      check_writes("b2b_init");
      for (int i = 0; i < COLS; i++) begin
         cycle(1'b1, rand_printable());
         n_checks++;
         if (vram_we !== 1'b1) $display("FAIL b2b_we[%0d]: got %b expected 1", i, vram_we);
         else n_pass++;
      end
      n_checks++;
      if (vram_x !== 7'(COLS - 1)) $display("FAIL b2b_last_x: got %0d expected %0d", vram_x, COLS - 1);
      else n_pass++;
      check_cursor("b2b");
      check_writes("b2b");
   endtask

   task automatic test_control_codes();
      do_reset("ctrl");
      wait_idle();
      check_writes("ctrl_init");
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h0A);
      cycle(1'b1, 8'h08);
      n_checks++;
      if (vram_we !== 1'b0) $display("FAIL ctrl_bs_col0_we: got %b expected 0", vram_we);
      else n_pass++;
      check_cursor("ctrl_bs_col0");
      for (int i = 0; i < 4; i++) cycle(1'b1, rand_printable());
      cycle(1'b1, 8'h08);
      n_checks++;
      if ({vram_we, vram_x, vram_y, vram_wdata} !== {1'b1, 7'd3, 5'd3, 8'h20})
         $display("FAIL ctrl_bs_write: got we=%b x=%0d y=%0d d=%h expected we=1 x=3 y=3 d=20",
                  vram_we, vram_x, vram_y, vram_wdata);
      else n_pass++;
      check_cursor("ctrl_bs");
      cycle(1'b1, 8'h07);
      n_checks++;
      if (vram_we !== 1'b0) $display("FAIL ctrl_bel_we: got %b expected 0", vram_we);
      else n_pass++;
      cycle(1'b1, 8'h80);
      n_checks++;
      if (vram_we !== 1'b0) $display("FAIL ctrl_80_we: got %b expected 0", vram_we);
      else n_pass++;
      check_cursor("ctrl_other");
      cycle(1'b1, 8'h0D);
      check_cursor("ctrl_cr");
      check_writes("ctrl");
   endtask

   task automatic test_scroll();
      do_reset("scroll");
      wait_idle();
      for (int i = 0; i < ROWS - 1; i++) cycle(1'b1, 8'h0A);
      for (int i = 0; i < 5; i++) cycle(1'b1, rand_printable());
      check_cursor("scroll_pre");
      cycle(1'b1, 8'h0A);
      wait_idle();
      check_cursor("scroll_lf");
      check_writes("scroll_lf");
      // Wrap on the bottom row with back-to-back printables.
      for (int i = 0; i < COLS + 3; i++) cycle(1'b1, rand_printable());
      wait_idle();
      check_cursor("scroll_wrap");
      check_writes("scroll_wrap");
   endtask

   task automatic test_reset_during_clear();
      do_reset("abort");
      wait_idle();
      for (int i = 0; i < ROWS; i++) cycle(1'b1, 8'h0A);
      for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00);
      do_reset("abort");
      wait_idle();
      check_writes("abort_restart");
      cycle(1'b1, 8'h5A);
      check_cursor("abort");
      check_writes("abort");
   endtask

   task automatic test_random();
      int r;
      logic [7:0] c;
      do_reset("random");
      wait_idle();
      for (int i = 0; i < 700; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      c = rand_printable();
         else if (r < 82) c = 8'h0A;
         else if (r < 87) c = 8'h0D;
         else if (r < 94) c = 8'h08;
         else             c = 8'($urandom_range(0, 255));
         cycle($urandom_range(0, 3) != 0, c);
      end
      wait_idle();
      check_cursor("random");
      check_writes("random");
   endtask

`ifdef VGA_WRITER_INIT_CLEAR_EN
   task automatic test_init_sweep();
      do_reset("init");
      for (int i = 0; i < 1000; i++) cycle(1'b0, 8'h00);
      n_checks++;
      if (obs_q.size() !== 1000) $display("FAIL init_partial_count: got %0d expected 1000", obs_q.size());
      else n_pass++;
      n_checks++;
      if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== {7'd19, 5'd14, 8'h20})
         $display("FAIL init_partial_last: got %0d writes, last not x=19 y=14 d=20", obs_q.size());
      else n_pass++;
      do_reset("init_restart");
      wait_idle();
      check_writes("init_full");
   endtask
`endif

   initial begin
      @(negedge pclk);
      test_reset();
      test_single_char();
      test_back_to_back();
      test_control_codes();
      test_scroll();
      test_reset_during_clear();
      test_random();
`ifdef VGA_WRITER_INIT_CLEAR_EN
      test_init_sweep();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
